// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
// Module   : prog_loader
// Purpose  : Loads a program from a host word stream into a console-driven
//            computer. The loader clears the machine, presents the start
//            address, then presents each host word on the console bus for a
//            fixed hold time in write-RAM mode. When the load ends it pulses
//            done.
// Option   : PROG_LOADER_VERIFY_EN adds a read-back pass. The machine is
//            cleared in read-RAM mode and led_out is summed over the loaded
//            words. The result is compared with the sum of the transferred
//            words, and a difference sets err.
// Ports    : clk, clr (sync active-high reset), start/start_addr (load
//            request), host_data/host_valid/host_last/host_ready (host word
//            stream), input_data/SWA/SWB/timing_clr/pc_clr (console drive),
//            led_out (machine read-back), busy/done/err/word_count (status).
// Revision : 1.0 - initial release
// ============================================================================
module prog_loader #(
  parameter int DATA_WIDTH  = 16,
  parameter int HOLD_CYCLES = 8,
  parameter int CLR_CYCLES  = 4,
  parameter int MAX_WORDS   = 255
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] start_addr,
  input  logic [DATA_WIDTH-1:0] host_data,
  input  logic                  host_valid,
  input  logic                  host_last,
  output logic                  host_ready,
  output logic [DATA_WIDTH-1:0] input_data,
  output logic                  SWA,
  output logic                  SWB,
  output logic                  timing_clr,
  output logic                  pc_clr,
  input  logic [DATA_WIDTH-1:0] led_out,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [7:0]            word_count
);

  localparam int CNT_MAX = (HOLD_CYCLES > CLR_CYCLES) ? HOLD_CYCLES : CLR_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_ADDR   = 3'd2,
    S_WAIT   = 3'd3,
    S_HOLD   = 3'd4,
    S_DONE   = 3'd5
`ifdef PROG_LOADER_VERIFY_EN
    ,
    S_VCLEAR = 3'd6,
    S_VREAD  = 3'd7
`endif
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [7:0]              wc_q, wc_d;
  logic                    err_q, err_d;
  logic                    last_q, last_d;   // word now being held carried host_last

  logic hold_end;
  logic clr_end;
  logic wc_at_max;

  assign hold_end  = (cnt_q == CNT_W'(HOLD_CYCLES - 1));
  assign clr_end   = (cnt_q == CNT_W'(CLR_CYCLES - 1));
  assign wc_at_max = ({1'b0, wc_q} >= 9'(MAX_WORDS));

`ifdef PROG_LOADER_VERIFY_EN
  logic [DATA_WIDTH-1:0] sum_q, sum_d;     // modular sum of transferred words
  logic [DATA_WIDTH-1:0] rsum_q, rsum_d;   // modular sum of read-back words
  logic [7:0]            rd_q, rd_d;       // read-back steps completed
  logic [DATA_WIDTH-1:0] rsum_add;

  assign rsum_add = rsum_q + led_out;
`else
  logic unused_led;
  assign unused_led = ^led_out;
`endif

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      wc_q    <= '0;
      err_q   <= 1'b0;
      last_q  <= 1'b0;
`ifdef PROG_LOADER_VERIFY_EN
      sum_q   <= '0;
      rsum_q  <= '0;
      rd_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wc_q    <= wc_d;
      err_q   <= err_d;
      last_q  <= last_d;
`ifdef PROG_LOADER_VERIFY_EN
      sum_q   <= sum_d;
      rsum_q  <= rsum_d;
      rd_q    <= rd_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + CNT_W'(1);
    addr_d     = addr_q;
    data_d     = data_q;
    wc_d       = wc_q;
    err_d      = err_q;
    last_d     = last_q;
`ifdef PROG_LOADER_VERIFY_EN
    sum_d      = sum_q;
    rsum_d     = rsum_q;
    rd_d       = rd_q;
`endif
    SWA        = 1'b0;
    SWB        = 1'b0;
    timing_clr = 1'b0;
    pc_clr     = 1'b0;
    host_ready = 1'b0;
    done       = 1'b0;
    busy       = (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (start) begin
          state_d = S_CLEAR;
          addr_d  = start_addr;
          wc_d    = '0;
          err_d   = 1'b0;
          last_d  = 1'b0;
`ifdef PROG_LOADER_VERIFY_EN
          sum_d   = '0;
`endif
        end
      end

      S_CLEAR: begin
        SWA        = 1'b1;
        timing_clr = 1'b1;
        pc_clr     = 1'b1;
        if (clr_end) begin
          state_d = S_ADDR;
          cnt_d   = '0;
          data_d  = addr_q;
        end
      end

      S_ADDR: begin
        SWA = 1'b1;
        if (hold_end) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end
      end

      S_WAIT: begin
        SWA        = 1'b1;
        host_ready = 1'b1;
        cnt_d      = '0;
        if (host_valid) begin
          state_d = S_HOLD;
          data_d  = host_data;
          last_d  = host_last;
          wc_d    = wc_at_max ? wc_q : wc_q + 8'd1;
          // Filling the last slot without a final marker means the host
          // program is too long; flag it now and stop after this hold.
          if (!host_last && (({1'b0, wc_q} + 9'd1) >= 9'(MAX_WORDS))) begin
            err_d = 1'b1;
          end
`ifdef PROG_LOADER_VERIFY_EN
          sum_d   = sum_q + host_data;
`endif
        end
      end

      S_HOLD: begin
        SWA = 1'b1;
        if (hold_end) begin
          cnt_d = '0;
          if (last_q) begin
`ifdef PROG_LOADER_VERIFY_EN
            state_d = S_VCLEAR;
            data_d  = addr_q;
`else
            state_d = S_DONE;
`endif
          end else if (wc_at_max) begin
            state_d = S_DONE;
          end else begin
            state_d = S_WAIT;
          end
        end
      end

`ifdef PROG_LOADER_VERIFY_EN
      S_VCLEAR: begin
        SWB        = 1'b1;
        timing_clr = 1'b1;
        pc_clr     = 1'b1;
        if (clr_end) begin
          state_d = S_VREAD;
          cnt_d   = '0;
          rd_d    = '0;
          rsum_d  = '0;
        end
      end

      // Each step presents address start_addr+rd_q and samples led_out on
      // the step's final cycle, after the machine has settled.
      S_VREAD: begin
        SWB = 1'b1;
        if (hold_end) begin
          cnt_d  = '0;
          rsum_d = rsum_add;
          rd_d   = rd_q + 8'd1;
          if ((rd_q + 8'd1) == wc_q) begin
            state_d = S_DONE;
            if (rsum_add != sum_q) begin
              err_d = 1'b1;
            end
          end else begin
            data_d = addr_q + DATA_WIDTH'(rd_q) + DATA_WIDTH'(1);
          end
        end
      end
`endif

      S_DONE: begin
        pc_clr  = 1'b1;
        done    = 1'b1;
        cnt_d   = '0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign input_data = data_q;
  assign word_count = wc_q;
  assign err        = err_q;

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_prog_loader
// Purpose  : Self-checking bench for prog_loader (MAX_WORDS=4). It runs
//            directed loads and random loads. The expected console timeline
//            of each load comes from the load rules: clear, address, waits,
//            holds, optional read-back, and done. Define
//            PROG_LOADER_VERIFY_EN to also exercise the read-back pass.
// Revision : 1.0 - initial release
// ============================================================================
module tb_prog_loader;
  localparam int DW = 16;
  localparam int HC = 8;
  localparam int CC = 4;
  localparam int MW = 4;

  // {SWB,SWA,timing_clr,pc_clr,host_ready,busy,done} per phase
  localparam logic [6:0] C_IDLE  = 7'b0000000;
  localparam logic [6:0] C_CLEAR = 7'b0111010;
  localparam logic [6:0] C_HOLD  = 7'b0100010;
  localparam logic [6:0] C_WAIT  = 7'b0100110;
  localparam logic [6:0] C_DONE  = 7'b0001011;
  localparam logic [6:0] C_VCLR  = 7'b1011010;
  localparam logic [6:0] C_VRD   = 7'b1000010;

  logic          clk = 1'b0;
  logic          clr, start, host_valid, host_last;
  logic [DW-1:0] start_addr, host_data, led_out, input_data;
  logic          host_ready, SWA, SWB, timing_clr, pc_clr, busy, done, err;
  logic [7:0]    word_count;
  logic [6:0]    ctl;

  int n_cmp = 0;
  int n_bad = 0;

  // Machine RAM model for read-back: word k lives at cur_addr+k.
  logic [DW-1:0] ram [0:255];
  logic [DW-1:0] wbuf [0:7];
  logic [DW-1:0] cur_addr;
  logic          corrupt;
  logic [7:0]    last_idx;
  logic [7:0]    led_idx;

  always #5 clk = ~clk;

  prog_loader #(.DATA_WIDTH(DW), .HOLD_CYCLES(HC), .CLR_CYCLES(CC), .MAX_WORDS(MW)) dut (
    .clk(clk), .clr(clr), .start(start), .start_addr(start_addr),
    .host_data(host_data), .host_valid(host_valid), .host_last(host_last),
    .host_ready(host_ready), .input_data(input_data), .SWA(SWA), .SWB(SWB),
    .timing_clr(timing_clr), .pc_clr(pc_clr), .led_out(led_out),
    .busy(busy), .done(done), .err(err), .word_count(word_count)
  );

  assign ctl     = {SWB, SWA, timing_clr, pc_clr, host_ready, busy, done};
  assign led_idx = 8'(input_data - cur_addr);

  always_comb begin
    led_out = '0;
    if (SWB && !SWA) begin
      led_out = ram[led_idx];
      if (corrupt && (led_idx == last_idx)) led_out = led_out ^ 16'h0001;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One load. gap<0 picks random idle cycles before each word; clr_word>=0
  // aborts with clr partway through that word's hold.
  task automatic do_load(input logic [DW-1:0] a, input int n, input bit with_last,
                         input int gap, input bit corr, input int clr_word);
    int acc;
    bit ex_err;
    bit fin;
    logic [DW-1:0] prev;
    acc = 0; ex_err = 1'b0; fin = 1'b0;
    cur_addr = a; corrupt = corr;
    start_addr = a; start = 1'b1;
    @(negedge clk);
    start = 1'b0; start_addr = DW'($urandom);
    for (int c = 0; c < CC; c++) begin
      chk("clear_ctl", ctl, C_CLEAR); chk("clear_wc", word_count, 0); chk("clear_err", err, 0);
      @(negedge clk);
    end
    for (int h = 0; h < HC; h++) begin
      chk("addr_ctl", ctl, C_HOLD); chk("addr_data", input_data, a);
      @(negedge clk);
    end
    prev = a;
    for (int i = 0; i < n && !fin; i++) begin
      int g;
      g = (gap >= 0) ? gap : int'($urandom_range(0, 3));
      for (int k = 0; k < g; k++) begin
        chk("wait_ctl", ctl, C_WAIT); chk("wait_data", input_data, prev);
        start = 1'($urandom_range(0, 1)); start_addr = DW'($urandom);
        host_valid = 1'b0; host_data = DW'($urandom); host_last = 1'($urandom);
        @(negedge clk);
      end
      chk("wait_ctl", ctl, C_WAIT);
      start = 1'b0; host_valid = 1'b1; host_data = wbuf[i];
      host_last = with_last && (i == n - 1);
      ram[acc] = wbuf[i];
      @(negedge clk);
      acc++; prev = wbuf[i];
      fin = host_last || (acc == MW);
      if (!host_last && acc == MW) ex_err = 1'b1;
      last_idx = 8'(acc - 1);
      for (int h = 0; h < HC; h++) begin
        host_valid = 1'($urandom); host_data = DW'($urandom); host_last = 1'($urandom);
        chk("hold_ctl", ctl, C_HOLD); chk("hold_data", input_data, wbuf[i]);
        chk("hold_wc", word_count, acc); chk("hold_err", err, ex_err);
        if (i == clr_word && h == 3) begin
          clr = 1'b1;
          @(negedge clk);
          clr = 1'b0; host_valid = 1'b0;
          chk("clr_ctl", ctl, C_IDLE); chk("clr_data", input_data, 0);
          chk("clr_wc", word_count, 0); chk("clr_err", err, 0);
          for (int k = 0; k < HC + 2; k++) begin
            @(negedge clk);
            chk("clr_no_done", ctl, C_IDLE);
          end
          return;
        end
        @(negedge clk);
      end
    end
    host_valid = 1'b0; host_last = 1'b0;
`ifdef PROG_LOADER_VERIFY_EN
    if (!ex_err) begin
      for (int c = 0; c < CC; c++) begin
        chk("vclr_ctl", ctl, C_VCLR); chk("vclr_data", input_data, a);
        @(negedge clk);
      end
      for (int k = 0; k < acc; k++) begin
        for (int h = 0; h < HC; h++) begin
          chk("vrd_ctl", ctl, C_VRD); chk("vrd_data", input_data, DW'(a + DW'(k)));
          @(negedge clk);
        end
      end
      ex_err = corr;
    end
`endif
    // Surplus words stay on offer during DONE; none may be taken.
    host_valid = (n > acc); host_data = DW'($urandom);
    chk("done_ctl", ctl, C_DONE); chk("done_err", err, ex_err); chk("done_wc", word_count, acc);
    @(negedge clk);
    host_valid = 1'b0;
    chk("idle_ctl", ctl, C_IDLE); chk("idle_err", err, ex_err); chk("idle_wc", word_count, acc);
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = '0;
    corrupt = 1'b0; cur_addr = '0; last_idx = '0;
    clr = 1'b1; start = 1'b1; start_addr = 16'hFFFF;
    host_valid = 1'b1; host_data = 16'hAAAA; host_last = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ctl", ctl, C_IDLE); chk("rst_data", input_data, 0);
    chk("rst_wc", word_count, 0); chk("rst_err", err, 0);
    clr = 1'b0; start = 1'b0; host_valid = 1'b0;
    @(negedge clk);
    chk("idle_ctl0", ctl, C_IDLE);

    // Basic three-word load
    wbuf[0] = 16'h1234; wbuf[1] = 16'h5678; wbuf[2] = 16'h9ABC;
    do_load(16'h0010, 3, 1'b1, 0, 1'b0, -1);
    // Long host stall in WAIT
    wbuf[0] = 16'hCAFE; wbuf[1] = 16'hBEEF;
    do_load(16'h0100, 2, 1'b1, 20, 1'b0, -1);
    // Overflow: six words without last, limit four
    for (int i = 0; i < 6; i++) wbuf[i] = DW'(16'h0A00 + i);
    do_load(16'h0200, 6, 1'b0, 0, 1'b0, -1);
    // Abort during second hold
    do_load(16'h0300, 3, 1'b1, 0, 1'b0, 1);
    // Read-back returns 0x9ABD for the third word
    wbuf[0] = 16'h1234; wbuf[1] = 16'h5678; wbuf[2] = 16'h9ABC;
    do_load(16'h0010, 3, 1'b1, 0, 1'b1, -1);
    do_load(16'h0010, 3, 1'b1, 1, 1'b0, -1);

    for (int r = 0; r < 20; r++) begin
      bit wl;
      int n;
      wl = 1'($urandom_range(0, 1));
      n  = wl ? int'($urandom_range(1, MW)) : MW + int'($urandom_range(0, 2));
      for (int i = 0; i < n; i++) wbuf[i] = DW'($urandom);
      do_load(DW'($urandom), n, wl, -1, 1'($urandom_range(0, 1)), (r % 7 == 3) ? 1 : -1);
    end

    // clr wins over a coincident start
    clr = 1'b1; start = 1'b1; start_addr = 16'h4321;
    @(negedge clk);
    clr = 1'b0; start = 1'b0;
    chk("clr_vs_start", ctl, C_IDLE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
